mdio_led_blinker: RTL
=====================

MDIO_LED_BLINKER -- requirements
Module: mdio_led_blinker

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 125000000, meaning the clk frequency in Hz.
REQ-002 SHALL have parameter BLINK_HZ, default 1, meaning the LED blink frequency in Hz; one full on+off cycle per period.
REQ-003 SHALL have parameter LED_REG_ADDR, 5 bits, default 5'h18, meaning the PHY LED control register address.
REQ-004 SHALL have parameter LED_ON_VALUE, 16 bits, default 16'h0030, meaning the register value that forces the link LEDs on.
REQ-005 SHALL have parameter LED_OFF_VALUE, 16 bits, default 16'h0036, meaning the register value that forces the link LEDs off.
REQ-006 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port axi_lite  axi_lite_interface Master modport  addr 5 / data 16  request port into the downstream MDIO master's Slave port.
REQ-009 SHALL have port led_state  output  1  the last value successfully written (1 = on).
REQ-010 SHALL have port busy  output  1  high while an AXI-lite transaction is outstanding.
REQ-011 SHALL have port bus_error  output  1  sticky flag; set on any BRESP/RRESP other than OKAY.
REQ-012 SHALL have port overrun  output  1  sticky flag; set when a toggle tick arrives while one is already pending.

Function
REQ-013 SHALL count clk cycles in a half-period counter with terminal count HALF = CLK_FREQ_HZ/(2*BLINK_HZ) - 1; at terminal count it wraps to 0 and emits a one-cycle tick.
REQ-014 SHALL hold a one-deep pending flag: tick sets it; entering WRITE clears it; tick while the flag is set and busy=1 sets overrun.
REQ-015 SHALL implement FSM states IDLE, WRITE, WAIT_B, and (with macro) READ_A, READ_D.
REQ-016 IDLE: when pending=1, SHALL latch target = ~led_state and go to WRITE on the next cycle.
REQ-017 WRITE: SHALL assert awvalid with awaddr = LED_REG_ADDR, and wvalid with wdata = target ? LED_ON_VALUE : LED_OFF_VALUE.
REQ-018 WRITE: each valid SHALL drop independently the cycle after its own ready handshake; AW and W may complete in either order or in the same cycle.
REQ-019 WRITE SHALL exit to WAIT_B only when both handshakes are complete; bready SHALL be asserted only in WAIT_B.
REQ-020 WAIT_B: on bvalid, led_state SHALL update to target if BRESP = OKAY, else bus_error SHALL be set and led_state kept; next state IDLE (or READ_A with macro).
REQ-021 All valids SHALL remain stable until accepted; no combinational path from ready to valid.
REQ-022 The tick counter SHALL run freely regardless of FSM state.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 Latency: pending to awvalid SHALL be 2 cycles (IDLE decision plus WRITE entry).

Reset
REQ-025 On reset, outputs SHALL be: awvalid=wvalid=bready=arvalid=rready=0, led_state=0, busy=0, bus_error=0, overrun=0; counter=0; state=IDLE.
REQ-026 Reset SHALL set pending=1, so the first post-reset action is a write of LED_ON_VALUE.
REQ-027 Reset asserted mid-transaction SHALL abandon it at that edge; the downstream MDIO master is reset from the same signal.

Configuration
REQ-028 Macro MDIO_LED_READBACK_EN defined: after a successful B response the FSM SHALL go to READ_A (arvalid, araddr = LED_REG_ADDR), then READ_D (rready).
REQ-029 With MDIO_LED_READBACK_EN defined, on rvalid the FSM SHALL set bus_error if RRESP is not OKAY or rdata differs from the written value, then return to IDLE.
REQ-030 Macro MDIO_LED_READBACK_EN undefined: no read states SHALL exist, arvalid=rready=0 constantly, and WAIT_B SHALL return directly to IDLE.

Verification (CLK_FREQ_HZ=20, BLINK_HZ=1, so HALF=9)
REQ-031 Reset release with a slave whose ready signals are always 1 -> awvalid=wvalid=1 at cycle 2, wdata=16'h0030, led_state=1 after bvalid.
REQ-032 Free run for 100 cycles -> writes spaced 10 cycles apart alternating 16'h0036/16'h0030, and led_state toggles on each write.
REQ-033 wready delayed 5 cycles behind awready -> awvalid drops first, wvalid is held stable, and there is exactly one B handshake.
REQ-034 bvalid withheld for 25 cycles -> overrun=1, followed by exactly one subsequent write once bvalid arrives.
REQ-035 BRESP=2'b10 -> bus_error=1 (sticky), led_state unchanged, and the next tick retries the same target.
REQ-036 Reset pulsed while in WRITE -> all valids are 0 on the next cycle, and the sequence restarts per REQ-031.

Source files
------------

// File: rtl/mdio_led_blinker_if.sv
// rtl/mdio_led_blinker_if.sv - AXI-lite request/response bundle between the blinker and the MDIO master
interface axi_lite_interface #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport Master (
        output awaddr, awvalid, input awready,
        output wdata, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport Slave (
        input awaddr, awvalid, output awready,
        input wdata, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/mdio_led_blinker.sv
// rtl/mdio_led_blinker.sv - toggles PHY link LEDs through an MDIO master at BLINK_HZ
// Optional register readback verification enabled by defining MDIO_LED_READBACK_EN.
module mdio_led_blinker #(
    parameter int          CLK_FREQ_HZ   = 125000000,
    parameter int          BLINK_HZ      = 1,
    parameter logic [4:0]  LED_REG_ADDR  = 5'h18,
    parameter logic [15:0] LED_ON_VALUE  = 16'h0030,
    parameter logic [15:0] LED_OFF_VALUE = 16'h0036
) (
    input  logic       clk,
    input  logic       reset,
    axi_lite_interface.Master axi_lite,
    output logic       led_state,
    output logic       busy,
    output logic       bus_error,
    output logic       overrun
);
    localparam int HALF  = CLK_FREQ_HZ / (2 * BLINK_HZ) - 1;
    localparam int CNT_W = (HALF > 0) ? $clog2(HALF + 1) : 1;
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF);

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WRITE  = 3'd1;
    localparam logic [2:0] WAIT_B = 3'd2;
`ifdef MDIO_LED_READBACK_EN
    localparam logic [2:0] READ_A = 3'd3;
    localparam logic [2:0] READ_D = 3'd4;
`endif

    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic             pending;
    logic             target;
    logic [2:0]       state;
    logic             aw_valid;
    logic             w_valid;
    logic [15:0]      wr_value;
    logic             enter_write;

    assign tick        = (cnt == HALF_CNT);
    assign enter_write = (state == IDLE) && pending;
    assign busy        = (state != IDLE);
    assign wr_value    = target ? LED_ON_VALUE : LED_OFF_VALUE;

    assign axi_lite.awaddr  = LED_REG_ADDR;
    assign axi_lite.awvalid = aw_valid;
    assign axi_lite.wdata   = wr_value;
    assign axi_lite.wvalid  = w_valid;
    assign axi_lite.bready  = (state == WAIT_B);
    assign axi_lite.araddr  = LED_REG_ADDR;

    always_ff @(posedge clk) begin
        if (reset || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // A tick coinciding with the IDLE->WRITE decision must not be lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 1'b1;
            overrun <= 1'b0;
        end else begin
            if (tick) begin
                pending <= 1'b1;
            end else if (enter_write) begin
                pending <= 1'b0;
            end
            if (tick && pending && busy) begin
                overrun <= 1'b1;
            end
        end
    end

`ifdef MDIO_LED_READBACK_EN
    logic ar_valid;
    assign axi_lite.arvalid = ar_valid;
    assign axi_lite.rready  = (state == READ_D);
`else
    logic unused_read;
    assign axi_lite.arvalid = 1'b0;
    assign axi_lite.rready  = 1'b0;
    assign unused_read = ^{axi_lite.arready, axi_lite.rvalid, axi_lite.rresp, axi_lite.rdata};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            target    <= 1'b0;
            led_state <= 1'b0;
            bus_error <= 1'b0;
            aw_valid  <= 1'b0;
            w_valid   <= 1'b0;
`ifdef MDIO_LED_READBACK_EN
            ar_valid  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pending) begin
                        target   <= ~led_state;
                        aw_valid <= 1'b1;
                        w_valid  <= 1'b1;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    // Each channel retires on its own handshake; leave once both have.
                    if (axi_lite.awready) begin
                        aw_valid <= 1'b0;
                    end
                    if (axi_lite.wready) begin
                        w_valid <= 1'b0;
                    end
                    if ((!aw_valid || axi_lite.awready) && (!w_valid || axi_lite.wready)) begin
                        state <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (axi_lite.bvalid) begin
                        if (axi_lite.bresp == RESP_OKAY) begin
                            led_state <= target;
`ifdef MDIO_LED_READBACK_EN
                            ar_valid  <= 1'b1;
                            state     <= READ_A;
`else
                            state     <= IDLE;
`endif
                        end else begin
                            bus_error <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
`ifdef MDIO_LED_READBACK_EN
                READ_A: begin
                    if (axi_lite.arready) begin
                        ar_valid <= 1'b0;
                        state    <= READ_D;
                    end
                end
                READ_D: begin
                    if (axi_lite.rvalid) begin
                        if ((axi_lite.rresp != RESP_OKAY) || (axi_lite.rdata != wr_value)) begin
                            bus_error <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
